// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges pipeline results with buffered MDU results onto one register-file write port.
// Optional macro WB_PERF_CNT_EN enables the MDU starvation-cycle counter on perf_stall_cnt_o.
module wb_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MDU_FIFO_DEPTH = 2,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              pipe_valid_i,
    input  logic                              pipe_we_i,
    input  logic [REG_ADDR_WIDTH-1:0]         pipe_rd_addr_i,
    input  logic [DATA_WIDTH-1:0]             pipe_rd_data_i,
    input  logic                              mdu_valid_i,
    output logic                              mdu_ready_o,
    input  logic [REG_ADDR_WIDTH-1:0]         mdu_rd_addr_i,
    input  logic [DATA_WIDTH-1:0]             mdu_rd_data_i,
    output logic                              write_en_o,
    output logic [REG_ADDR_WIDTH-1:0]         rd_addr_o,
    output logic [DATA_WIDTH-1:0]             rd_data_o,
    output logic                              stall_req_o,
    output logic                              busy_o,
    output logic [$clog2(MDU_FIFO_DEPTH):0]   fifo_count_o,
    output logic [31:0]                       perf_stall_cnt_o
);

    localparam int PTR_W = $clog2(MDU_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

    logic [DATA_WIDTH-1:0]     fifo_data [MDU_FIFO_DEPTH];
    logic [REG_ADDR_WIDTH-1:0] fifo_addr [MDU_FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;
    logic [CNT_W-1:0]          count;
    logic [AGE_W-1:0]          age;
    logic [AGE_W-1:0]          age_next;

    logic fifo_nonempty;
    logic mdu_accept;
    logic push;
    logic pop;
    logic pipe_cand;
    logic pipe_win;
    logic stall_next;

    assign fifo_nonempty = (count != '0);
    assign mdu_ready_o   = !rst_i && (count < CNT_W'(MDU_FIFO_DEPTH));
    assign mdu_accept    = mdu_valid_i && mdu_ready_o;
    // x0 results complete the handshake but are dropped here.
    assign push          = mdu_accept && (mdu_rd_addr_i != '0);
    assign pipe_cand     = pipe_valid_i && pipe_we_i && (pipe_rd_addr_i != '0);
    assign busy_o        = fifo_nonempty;
    assign fifo_count_o  = count;

    always_comb begin
        pop      = 1'b0;
        pipe_win = 1'b0;
        if (stall_req_o && fifo_nonempty) begin
            pop = 1'b1;
        end else if (pipe_cand) begin
            pipe_win = 1'b1;
        end else if (fifo_nonempty) begin
            pop = 1'b1;
        end
    end

    always_comb begin
        age_next   = age;
        stall_next = 1'b0;
        if (!fifo_nonempty || pop) begin
            age_next = '0;
        end else begin
            if (age != AGE_W'(STARVE_LIMIT)) begin
                age_next = age + AGE_W'(1);
            end
            // High the cycle age reaches the limit, held while the head still waits.
            stall_next = (age == AGE_W'(STARVE_LIMIT - 1)) || (age == AGE_W'(STARVE_LIMIT));
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_data[wr_ptr] <= mdu_rd_data_i;
            fifo_addr[wr_ptr] <= mdu_rd_addr_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            age         <= '0;
            stall_req_o <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            age         <= age_next;
            stall_req_o <= stall_next;
        end
    end

    // Address/data hold their last value when no write is issued.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            write_en_o <= 1'b0;
            rd_addr_o  <= '0;
            rd_data_o  <= '0;
        end else if (pipe_win) begin
            write_en_o <= 1'b1;
            rd_addr_o  <= pipe_rd_addr_i;
            rd_data_o  <= pipe_rd_data_i;
        end else if (pop) begin
            write_en_o <= 1'b1;
            rd_addr_o  <= fifo_addr[rd_ptr];
            rd_data_o  <= fifo_data[rd_ptr];
        end else begin
            write_en_o <= 1'b0;
        end
    end

`ifdef WB_PERF_CNT_EN
    logic [31:0] perf_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_cnt <= '0;
        end else if (fifo_nonempty && pipe_win) begin
            perf_cnt <= perf_cnt + 32'd1;
        end
    end

    assign perf_stall_cnt_o = perf_cnt;
`else
    assign perf_stall_cnt_o = '0;
`endif

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(stall_req_o && pipe_valid_i))
                else $error("wb_arbiter: pipeline result presented while stall_req_o high, result lost");
            assert (!(write_en_o && (rd_addr_o == '0)))
                else $error("wb_arbiter: write to x0 presented");
        end
    end
`endif

endmodule
